// File: rtl/clock_enable_gen.sv
// Lock-qualified multi-channel fractional clock-enable generator.
// Optional square-wave outputs are enabled with `define CLKEN_GEN_SQUARE_EN.
module clock_enable_gen #(
   parameter int CH          = 2,
   parameter int ACC_W       = 24,
   parameter int INC_DEFAULT = 798915,
   parameter int LOCK_WAIT   = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pll_lock,
   input  logic             inc_wr,
   input  logic [2:0]       inc_ch,
   input  logic [ACC_W-1:0] inc_data,
   input  logic             lost_clr,
   output logic             ready,
   output logic [CH-1:0]    en,
   output logic             lost_lock
`ifdef CLKEN_GEN_SQUARE_EN
   ,
   output logic [CH-1:0]    sq
`endif
);

   localparam int CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LOCK_WAIT - 1);
   localparam logic [ACC_W-1:0] INC_RST = ACC_W'(INC_DEFAULT);

   typedef enum logic [1:0] {
      WAIT_LOCK,
      SETTLE,
      RUN
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nx;
   logic            sync1;
   logic            lock_s;
   logic            run_go;
   logic [ACC_W-1:0] acc [CH];
   logic [ACC_W-1:0] inc [CH];
   logic [ACC_W:0]   sum [CH];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync1  <= pll_lock;
         lock_s <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= WAIT_LOCK;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nx = SETTLE;
               cnt_nx   = '0;
            end
         end
         SETTLE: begin
            if (!lock_s)
               state_nx = WAIT_LOCK;
            else if (cnt == LAST)
               state_nx = RUN;
            else
               cnt_nx = cnt + CW'(1);
         end
         RUN: begin
            if (!lock_s)
               state_nx = WAIT_LOCK;
         end
         default: state_nx = WAIT_LOCK;
      endcase
   end

   assign ready = (state == RUN);
   // Clearing on the same edge that leaves RUN keeps channels phase-aligned.
   assign run_go = (state == RUN) && lock_s;

   always_ff @(posedge clk) begin
      if (reset)
         lost_lock <= 1'b0;
      else if ((state != WAIT_LOCK) && !lock_s)
         lost_lock <= 1'b1;
      else if (lost_clr)
         lost_lock <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CH; i++)
            inc[i] <= INC_RST;
      end else if (inc_wr) begin
         for (int i = 0; i < CH; i++)
            if (inc_ch == 3'(i))
               inc[i] <= inc_data;
      end
   end

   always_comb begin
      for (int i = 0; i < CH; i++)
         sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
   end

   always_ff @(posedge clk) begin
      if (reset || !run_go) begin
         for (int i = 0; i < CH; i++)
            acc[i] <= '0;
         en <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            acc[i] <= sum[i][ACC_W-1:0];
            en[i]  <= sum[i][ACC_W];
         end
      end
   end

`ifdef CLKEN_GEN_SQUARE_EN
   always_ff @(posedge clk) begin
      if (reset || !run_go)
         sq <= '0;
      else
         sq <= sq ^ en;
   end
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen: release timing, rates,
// write corner cases, lock loss, relock and mid-run reset.
module tb_clock_enable_gen;

   localparam int CH = 2;
   localparam int ACC_W = 24;
   localparam int LW = 16;
   localparam longint unsigned INC1 = 798915;

   logic             clk;
   logic             reset;
   logic             pll_lock;
   logic             inc_wr;
   logic [2:0]       inc_ch;
   logic [ACC_W-1:0] inc_data;
   logic             lost_clr;
   logic             ready;
   logic [CH-1:0]    en;
   logic             lost_lock;
`ifdef CLKEN_GEN_SQUARE_EN
   logic [CH-1:0]    sq;
`endif

   int checks;
   int failures;
   longint unsigned run_t;
   logic [CH-1:0] exp_q [$];

   clock_enable_gen #(
      .CH(CH),
      .ACC_W(ACC_W),
      .INC_DEFAULT(798915),
      .LOCK_WAIT(LW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pll_lock(pll_lock),
      .inc_wr(inc_wr),
      .inc_ch(inc_ch),
      .inc_data(inc_data),
      .lost_clr(lost_clr),
      .ready(ready),
      .en(en),
      .lost_lock(lost_lock)
`ifdef CLKEN_GEN_SQUARE_EN
      ,
      .sq(sq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse at RUN edge t iff floor(t*inc/2^24) steps up at t.
   function automatic logic exp_bit(longint unsigned t,
                                    longint unsigned inc);
      return ((t * inc) >> 24) != (((t - 1) * inc) >> 24);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pll_lock = 1'b0;
      inc_wr = 1'b0;
      inc_ch = '0;
      inc_data = '0;
      lost_clr = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_ready got=%b exp=0", ready);
      end
      checks++;
      if (en !== '0) begin
         failures++;
         $display("FAIL rst_en got=%b exp=00", en);
      end
      checks++;
      if (lost_lock !== 1'b0) begin
         failures++;
         $display("FAIL rst_lost got=%b exp=0", lost_lock);
      end
`ifdef CLKEN_GEN_SQUARE_EN
      checks++;
      if (sq !== '0) begin
         failures++;
         $display("FAIL rst_sq got=%b exp=00", sq);
      end
`endif
      reset = 1'b0;
      tick();
   endtask

   task automatic test_release();
      inc_wr = 1'b1;
      inc_ch = 3'd0;
      inc_data = 24'd4194304;
      tick();
      inc_wr = 1'b0;
      pll_lock = 1'b1;
      for (int e = 0; e < 18; e++) begin
         tick();
         checks++;
         if ({ready, en} !== 3'b000) begin
            failures++;
            $display("FAIL settle e=%0d got=%b exp=000",
                     e, {ready, en});
         end
      end
      tick();
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL release got=%b exp=1", ready);
      end
      run_t = 0;
   endtask

   task automatic test_rates();
      logic [CH-1:0] e;
      int npulse;
      int bad_gap;
      longint unsigned last;
      npulse = 0;
      bad_gap = 0;
      last = 0;
      for (int n = 0; n < 200; n++) begin
         run_t++;
         exp_q.push_back({exp_bit(run_t, INC1), run_t % 4 == 0});
         tick();
         e = exp_q.pop_front();
         checks++;
         if (en !== e) begin
            failures++;
            $display("FAIL rate t=%0d got=%b exp=%b", run_t, en, e);
         end
`ifdef CLKEN_GEN_SQUARE_EN
         checks++;
         if (sq[0] !== 1'(((run_t - 1) / 4) % 2)) begin
            failures++;
            $display("FAIL sq t=%0d got=%b", run_t, sq[0]);
         end
`endif
         if (en[1] === 1'b1) begin
            if (last != 0 && run_t - last != 21 && run_t - last != 22)
               bad_gap++;
            last = run_t;
            npulse++;
         end
      end
      checks++;
      if (longint'(npulse) != longint'((200 * INC1) >> 24)) begin
         failures++;
         $display("FAIL frac_count got=%0d exp=%0d",
                  npulse, (200 * INC1) >> 24);
      end
      checks++;
      if (bad_gap != 0) begin
         failures++;
         $display("FAIL frac_gap got=%0d exp=0", bad_gap);
      end
   endtask

   task automatic test_write_corners();
      logic [CH-1:0] e;
      logic e0;
      for (int n = 0; n < 60; n++) begin
         run_t++;
         inc_wr = 1'b0;
         if (run_t == 204) begin
            inc_wr = 1'b1;
            inc_ch = 3'd0;
            inc_data = 24'd8388608;
         end else if (run_t == 209) begin
            inc_wr = 1'b1;
            inc_ch = 3'd0;
            inc_data = 24'd0;
         end else if (run_t == 220) begin
            inc_wr = 1'b1;
            inc_ch = 3'd7;
            inc_data = 24'hFFFFFF;
         end
         if (run_t <= 204)
            e0 = (run_t % 4 == 0);
         else if (run_t <= 208)
            e0 = (run_t % 2 == 0);
         else
            e0 = 1'b0;
         exp_q.push_back({exp_bit(run_t, INC1), e0});
         tick();
         inc_wr = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (en !== e) begin
            failures++;
            $display("FAIL wr t=%0d got=%b exp=%b", run_t, en, e);
         end
      end
   endtask

   task automatic test_lock_loss();
      lost_clr = 1'b1;
      pll_lock = 1'b0;
      tick();
      tick();
      checks++;
      if (lost_lock !== 1'b0) begin
         failures++;
         $display("FAIL lost_early got=%b exp=0", lost_lock);
      end
      tick();
      lost_clr = 1'b0;
      checks++;
      if ({ready, en} !== 3'b000) begin
         failures++;
         $display("FAIL loss_out got=%b exp=000", {ready, en});
      end
      checks++;
      if (lost_lock !== 1'b1) begin
         failures++;
         $display("FAIL lost_set got=%b exp=1", lost_lock);
      end
`ifdef CLKEN_GEN_SQUARE_EN
      checks++;
      if (sq !== '0) begin
         failures++;
         $display("FAIL loss_sq got=%b exp=00", sq);
      end
`endif
      tick();
      tick();
   endtask

   task automatic test_relock();
      logic [CH-1:0] e;
      pll_lock = 1'b1;
      for (int k = 0; k < 18; k++) begin
         tick();
         checks++;
         if ({ready, en} !== 3'b000) begin
            failures++;
            $display("FAIL resettle k=%0d got=%b", k, {ready, en});
         end
      end
      tick();
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL relock got=%b exp=1", ready);
      end
      checks++;
      if (lost_lock !== 1'b1) begin
         failures++;
         $display("FAIL sticky got=%b exp=1", lost_lock);
      end
      run_t = 0;
      for (int n = 0; n < 50; n++) begin
         run_t++;
         exp_q.push_back({exp_bit(run_t, INC1), 1'b0});
         tick();
         e = exp_q.pop_front();
         checks++;
         if (en !== e) begin
            failures++;
            $display("FAIL relock_en t=%0d got=%b exp=%b",
                     run_t, en, e);
         end
      end
      lost_clr = 1'b1;
      tick();
      lost_clr = 1'b0;
      checks++;
      if (lost_lock !== 1'b0) begin
         failures++;
         $display("FAIL lost_clr got=%b exp=0", lost_lock);
      end
   endtask

   task automatic test_reset_midrun();
      logic [CH-1:0] e;
      int waited;
      inc_wr = 1'b1;
      inc_ch = 3'd1;
      inc_data = 24'd123;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      inc_wr = 1'b0;
      checks++;
      if ({ready, en, lost_lock} !== 4'b0000) begin
         failures++;
         $display("FAIL mid_rst got=%b exp=0000",
                  {ready, en, lost_lock});
      end
      waited = 0;
      while (ready !== 1'b1 && waited < 60) begin
         tick();
         waited++;
      end
      checks++;
      if (waited != 19) begin
         failures++;
         $display("FAIL rst_release got=%0d exp=19", waited);
      end
      run_t = 0;
      for (int n = 0; n < 60; n++) begin
         run_t++;
         exp_q.push_back({exp_bit(run_t, INC1), exp_bit(run_t, INC1)});
         tick();
         e = exp_q.pop_front();
         checks++;
         if (en !== e) begin
            failures++;
            $display("FAIL rst_inc t=%0d got=%b exp=%b", run_t, en, e);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      run_t = 0;
      test_reset();
      test_release();
      test_rates();
      test_write_corners();
      test_lock_loss();
      test_relock();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
